// File: rtl/uart_alu_pkg.sv
// Definitions shared between the UART ALU command parser and the response framer.
package uart_alu_pkg;

    typedef logic [7:0] opcode_t;

    localparam opcode_t RespReservedByte = 8'h00;
    localparam int      RespHeaderBytes  = 4;

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Header = 2'd1,
        Data   = 2'd2
    } resp_state_e;

endpackage : uart_alu_pkg

// File: rtl/uart_alu_resp_framer.sv
// Serializes one ALU result (opcode + word) into a little-endian response packet
// on a byte-wide valid/ready stream feeding uart_tx.
module uart_alu_resp_framer
    import uart_alu_pkg::*;
#(
    parameter int WordWidth   = 32,
    parameter int OpcodeWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [OpcodeWidth-1:0] res_opcode_i,
    input  logic [WordWidth-1:0]   res_data_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    output logic [7:0]             m_axis_tdata_o,
    output logic                   m_axis_tvalid_o,
    input  logic                   m_axis_tready_i,
    output logic                   busy_o
);

    localparam int DataBytes = WordWidth / 8;
    localparam int PktLen    = RespHeaderBytes + DataBytes;
    localparam int IdxW      = $clog2(PktLen);

    localparam logic [15:0]     PktLenField = 16'(PktLen);
    localparam logic [IdxW-1:0] IdxOne      = IdxW'(1);
    localparam logic [IdxW-1:0] LastHdrIdx  = IdxW'(RespHeaderBytes - 1);
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(PktLen - 1);

    resp_state_e            state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    opcode_t                opcode_q, opcode_d;
    logic [WordWidth-1:0]   data_q, data_d;

    // The index runs across the whole packet (header and data) and is cleared
    // on the final byte, so it never wraps.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opcode_d = opcode_q;
        data_d   = data_q;

        case (state_q)
            Idle: begin
                if (res_valid_i) begin
                    opcode_d = opcode_t'(res_opcode_i);
                    data_d   = res_data_i;
                    idx_d    = '0;
                    state_d  = Header;
                end
            end
            Header: begin
                if (m_axis_tready_i) begin
                    idx_d = idx_q + IdxOne;
                    if (idx_q == LastHdrIdx) begin
                        state_d = Data;
                    end
                end
            end
            Data: begin
                if (m_axis_tready_i) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = Idle;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    // Byte mux decodes only from registered state, so tdata is stable under backpressure.
    always_comb begin
        m_axis_tdata_o = 8'h00;
        case (state_q)
            Header: begin
                case (idx_q)
                    IdxW'(0): m_axis_tdata_o = opcode_q;
                    IdxW'(1): m_axis_tdata_o = RespReservedByte;
                    IdxW'(2): m_axis_tdata_o = PktLenField[7:0];
                    default:  m_axis_tdata_o = PktLenField[15:8];
                endcase
            end
            Data: begin
                for (int k = 0; k < DataBytes; k++) begin
                    if (idx_q == IdxW'(RespHeaderBytes + k)) begin
                        m_axis_tdata_o = data_q[8*k +: 8];
                    end
                end
            end
            default: begin
                m_axis_tdata_o = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= Idle;
            idx_q    <= '0;
            opcode_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            data_q   <= data_d;
        end
    end

    assign res_ready_o     = (state_q == Idle);
    assign m_axis_tvalid_o = (state_q != Idle);
    assign busy_o          = (state_q != Idle);

endmodule : uart_alu_resp_framer
